// File: rtl/song_reader.sv
// Song ROM note sequencer feeding note_counter: fetches one note per step and reports end of song.
// Optional build macro REPEAT_EN: loop the song instead of parking in DONE.
module song_reader #(
  parameter int NOTES_PER_SONG = 32,
  parameter int SONG_BITS      = 2,
  parameter int ROM_WIDTH      = 12,
  localparam int IDX_W         = $clog2(NOTES_PER_SONG)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic [SONG_BITS-1:0]       song,
  input  logic                       note_done,
  output logic [SONG_BITS+IDX_W-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]       rom_data,
  output logic [5:0]                 note,
  output logic [5:0]                 duration,
  output logic                       new_note,
  output logic                       timer_clear,
  output logic                       song_done,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PLAYING = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [5:0]           note_q, note_d;
  logic [5:0]           dur_q, dur_d;
  logic                 new_note_q, new_note_d;
  logic                 timer_clear_q, timer_clear_d;
  logic                 song_done_q, song_done_d;
  logic                 finish;
  logic                 active;

  assign active = (state_q == FETCH) || (state_q == LOAD) || (state_q == PLAYING);

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    song_d        = song_q;
    note_d        = note_q;
    dur_d         = dur_q;
    new_note_d    = 1'b0;
    timer_clear_d = 1'b0;
`ifdef REPEAT_EN
    song_done_d   = 1'b0;
`else
    song_done_d   = song_done_q;
`endif
    finish        = 1'b0;

    // Dropping play rewinds from anywhere and outranks every other event.
    if (state_q != IDLE && !play) begin
      state_d     = IDLE;
      index_d     = '0;
      song_done_d = 1'b0;
      note_d      = 6'd0;
    end else if (active && song != song_q) begin
      song_d  = song;
      index_d = '0;
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            song_d  = song;
            index_d = '0;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (rom_data[5:0] == 6'd0) begin
            finish = 1'b1;
          end else begin
            note_d        = rom_data[11:6];
            dur_d         = rom_data[5:0];
            new_note_d    = 1'b1;
            timer_clear_d = 1'b1;
            state_d       = PLAYING;
          end
        end
        PLAYING: begin
          if (note_done) begin
            if (index_q == IDX_W'(NOTES_PER_SONG - 1)) begin
              finish = 1'b1;
            end else begin
              index_d = index_q + IDX_W'(1);
              state_d = FETCH;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end

    if (finish) begin
`ifdef REPEAT_EN
      song_done_d = 1'b1;
      index_d     = '0;
      state_d     = FETCH;
`else
      song_done_d = 1'b1;
      note_d      = 6'd0;
      state_d     = DONE;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      song_q        <= '0;
      note_q        <= 6'd0;
      dur_q         <= 6'd0;
      new_note_q    <= 1'b0;
      timer_clear_q <= 1'b0;
      song_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      song_q        <= song_d;
      note_q        <= note_d;
      dur_q         <= dur_d;
      new_note_q    <= new_note_d;
      timer_clear_q <= timer_clear_d;
      song_done_q   <= song_done_d;
    end
  end

  assign rom_addr    = {song_q, index_q};
  assign note        = note_q;
  assign duration    = dur_q;
  assign new_note    = new_note_q;
  assign timer_clear = timer_clear_q;
  assign song_done   = song_done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: vector table, hand-written corner sequences and a
// randomized song walk checked against a per-song expected note queue.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        timer_clear;
  logic        song_done;
  logic [2:0]  state_dbg;

  logic [11:0] rom [0:127];
  logic [11:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  song;
    logic [11:0] word;
    logic [6:0]  exp_addr;
    logic [5:0]  exp_note;
    logic [5:0]  exp_dur;
    logic        exp_nn;
    logic        exp_done;
  } vec_t;

  vec_t vecs [6];

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song       (song),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .timer_clear(timer_clear),
    .song_done  (song_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  task automatic rewind();
    play = 1'b0;
    note_done = 1'b0;
    tick();
    tick();
  endtask

  int          cnt;
  int          pos;
  int          nn_seen;
  logic        saw65;
  logic        finished;
  logic [1:0]  s;
  logic [11:0] e;
  logic [5:0]  rn, rd;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 12'h000;
    reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;

    vecs[0] = '{2'd0, {6'h05, 6'd3},  7'd0,  6'h05, 6'd3,  1'b1, 1'b0};
    vecs[1] = '{2'd1, {6'h3F, 6'd63}, 7'd32, 6'h3F, 6'd63, 1'b1, 1'b0};
    vecs[2] = '{2'd2, {6'h11, 6'd4},  7'd64, 6'h11, 6'd4,  1'b1, 1'b0};
    vecs[3] = '{2'd3, {6'h00, 6'd1},  7'd96, 6'h00, 6'd1,  1'b1, 1'b0};
    vecs[4] = '{2'd1, {6'h2A, 6'd0},  7'd32, 6'h00, 6'd0,  1'b0, 1'b1};
    vecs[5] = '{2'd3, {6'h3F, 6'd0},  7'd96, 6'h00, 6'd0,  1'b0, 1'b1};

    tick(); tick();
    check("rst_new_note", new_note, 0);
    check("rst_timer_clear", timer_clear, 0);
    check("rst_song_done", song_done, 0);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;
    tick();

    // Vector table: first slot of a song, checked three edges after play rises.
    for (int v = 0; v < 6; v++) begin
      rewind();
      rom[{vecs[v].song, 5'd0}] = vecs[v].word;
      song = vecs[v].song;
      play = 1'b1;
      tick();
      check("vec_fetch_addr", rom_addr, vecs[v].exp_addr);
      tick();
      check("vec_load_nn", new_note, 0);
      tick();
      check("vec_new_note", new_note, vecs[v].exp_nn);
      check("vec_timer_clear", timer_clear, vecs[v].exp_nn);
      check("vec_song_done", song_done, vecs[v].exp_done);
      check("vec_note", note, vecs[v].exp_note);
      if (vecs[v].exp_nn) check("vec_duration", duration, vecs[v].exp_dur);
      tick();
      check("vec_nn_one_cycle", new_note, 0);
    end

    // Song 2: note, rest, then end marker.
    rewind();
    rom[64] = {6'h11, 6'd4};
    rom[65] = {6'h00, 6'd2};
    rom[66] = 12'h000;
    song = 2'd2;
    play = 1'b1;
    tick();
    check("a_addr64", rom_addr, 64);
    tick();
    tick();
    check("a_nn1", new_note, 1);
    check("a_tc1", timer_clear, 1);
    check("a_note1", note, 6'h11);
    check("a_dur1", duration, 4);
    tick();
    check("a_nn1_drop", new_note, 0);
    check("a_tc1_drop", timer_clear, 0);
    pulse_done();
    check("a_addr65", rom_addr, 65);
    check("a_hold_note", note, 6'h11);
    tick();
    check("a_gap_nn", new_note, 0);
    tick();
    check("a_nn2", new_note, 1);
    check("a_note2", note, 0);
    check("a_dur2", duration, 2);
    pulse_done();
    check("a_addr66", rom_addr, 66);
    tick();
    tick();
    check("a_marker_nn", new_note, 0);
    check("a_marker_done", song_done, 1);
`ifdef REPEAT_EN
    check("a_loop_addr", rom_addr, 64);
    tick();
    check("a_done_pulse", song_done, 0);
`else
    check("a_done_note", note, 0);
    pulse_done();
    tick();
    check("a_done_held", song_done, 1);
    check("a_done_dur", duration, 2);
    check("a_done_nn", new_note, 0);
`endif
    play = 1'b0;
    tick();
    check("a_stop_done", song_done, 0);
    check("a_stop_note", note, 0);

    // Asynchronous reset in the middle of a note.
    rewind();
    rom[0] = {6'h1A, 6'd8};
    song = 2'd0;
    play = 1'b1;
    tick(); tick(); tick();
    check("r_note", note, 6'h1A);
    check("r_dur", duration, 8);
    #3 reset = 1'b1;
    #1;
    check("r_note0", note, 0);
    check("r_dur0", duration, 0);
    check("r_nn0", new_note, 0);
    check("r_tc0", timer_clear, 0);
    check("r_done0", song_done, 0);
    check("r_addr0", rom_addr, 0);
    play = 1'b0;
    #2 reset = 1'b0;
    tick();

    // Song change 2->3 on the same edge as note_done.
    rewind();
    rom[64] = {6'h11, 6'd4};
    rom[96] = {6'h22, 6'd5};
    song = 2'd2;
    play = 1'b1;
    tick(); tick(); tick();
    song = 2'd3;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    check("c_addr96", rom_addr, 96);
    saw65 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rom_addr == 7'd65) saw65 = 1'b1;
      tick();
    end
    check("c_no_addr65", saw65, 0);
    check("c_nn", new_note, 1);
    check("c_note", note, 6'h22);
    check("c_dur", duration, 5);

    // play dropped while fetching: no note is issued.
    rewind();
    song = 2'd1;
    play = 1'b1;
    tick();
    check("d_fetch_addr", rom_addr, 32);
    play = 1'b0;
    nn_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (new_note) nn_seen++;
    end
    check("d_no_new_note", nn_seen, 0);
    check("d_rewind_addr", rom_addr, 32);
    check("d_song_done", song_done, 0);

    // Randomized songs: the queue holds every note up to the first end marker.
    for (int it = 0; it < 6; it++) begin
      s = 2'($urandom_range(0, 3));
      pos = (it % 2 == 0) ? 32 : $urandom_range(1, 31);
      for (int i = 0; i < 32; i++) begin
        rn = 6'($urandom_range(0, 63));
        rd = (i == pos) ? 6'd0 : 6'($urandom_range(1, 63));
        rom[{s, 5'(i)}] = {rn, rd};
      end
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        if (rom[{s, 5'(i)}][5:0] == 6'd0) break;
        exp_q.push_back(rom[{s, 5'(i)}]);
      end
      rewind();
      song = s;
      play = 1'b1;
      finished = 1'b0;
      for (int k = 0; k < 40 && !finished; k++) begin
        cnt = 0;
        while (!new_note && !song_done && cnt < 12) begin
          tick();
          cnt++;
        end
        if (cnt >= 12) begin
          check("rand_timeout", cnt, 0);
          finished = 1'b1;
        end else if (new_note) begin
          check("rand_queue_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rand_note_dur", {note, duration}, e);
          end
          repeat ($urandom_range(0, 3)) tick();
          pulse_done();
        end else begin
          check("rand_remaining", exp_q.size(), 0);
          finished = 1'b1;
        end
      end
`ifdef REPEAT_EN
      tick();
      check("rand_done_pulse", song_done, 0);
`else
      nn_seen = 0;
      pulse_done();
      for (int i = 0; i < 3; i++) begin
        tick();
        if (new_note) nn_seen++;
      end
      check("rand_done_held", song_done, 1);
      check("rand_no_note_after_done", nn_seen, 0);
`endif
    end

    play = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
Note sequencer directly upstream of note_counter. It walks a song ROM one note at a time and hands each note's pitch code and duration to the note player. It loads duration_to_load into note_counter, clears it, and advances on note_counter's timer_done. It reports end-of-song to the top-level play controller.

Parameters:
NOTES_PER_SONG, 32, notes per song slot; note index width = log2(NOTES_PER_SONG) = 5
SONG_BITS, 2, width of song select (4 songs)
ROM_WIDTH, 12, ROM word = {note[11:6], duration[5:0]}

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
play  input  1  level; high = run sequencer, low = stop and rewind
song  input  SONG_BITS  song select; sampled (latched) when leaving IDLE
note_done  input  1  from note_counter timer_done; current note finished
rom_addr  output  SONG_BITS+5  ROM address = {latched song, note index}
rom_data  input  ROM_WIDTH  ROM word, valid 1 cycle after rom_addr (synchronous ROM)
note  output  6  pitch code of current note (0 = rest), to note player
duration  output  6  beats of current note, to note_counter duration_to_load
new_note  output  1  one-cycle pulse: note/duration just updated
timer_clear  output  1  one-cycle pulse coincident with new_note, to note_counter
song_done  output  1  level; song finished

Behaviour:
- Reset (async, any state, including mid-song): state IDLE, index 0, latched song 0, note 0, duration 0, new_note 0, timer_clear 0, song_done 0. rom_addr = 0. All outputs are registered except rom_addr, which is {latched song, index}.
- States: IDLE, FETCH, LOAD, PLAYING, DONE.
- IDLE:
  - play = 0: stay.
  - play = 1: latch song, index = 0, go to FETCH.
- FETCH: one cycle with rom_addr stable. Always go to LOAD.
- LOAD: rom_data is valid and is captured.
  - duration field == 0 (end marker): go to DONE. note and duration are not updated.
  - Otherwise: note <= rom_data[11:6], duration <= rom_data[5:0], new_note = 1 and timer_clear = 1 for exactly one cycle, go to PLAYING.
- Latency: play sampled at edge k gives FETCH after edge k, LOAD after k+1, and new_note/timer_clear high for the cycle after edge k+2.
- PLAYING:
  - note_done = 1 and index == NOTES_PER_SONG-1: go to DONE.
  - note_done = 1 otherwise: index + 1, go to FETCH.
  - note_done = 0: hold; note and duration stay stable.
- Next-note latency: note_done sampled at edge m gives new_note high for the cycle after edge m+2. Outputs hold the previous note during the gap.
- DONE: song_done = 1 (level). note = 0, duration unchanged. Stay until play = 0.
- play = 0 in any non-IDLE state: next state IDLE, index 0, song_done 0, note 0. No new_note pulse. Takes priority over every other event.
- Song change: song != latched song while in FETCH, LOAD or PLAYING (play = 1) triggers a restart. Latch the new song, index 0, go to FETCH. Song change wins over a simultaneous note_done. In DONE, a song change is ignored until a play 0→1 cycle.
- note_done outside PLAYING is ignored.
- Index does not wrap silently: reaching the last slot ends the song.

Optional Feature:
REPEAT_EN. When defined, wherever the block would enter DONE (end marker or last slot) it instead pulses song_done for one cycle, sets index 0 and goes to FETCH, so the song loops. When not defined, DONE is entered and song_done is a held level as above.

Test Plan:
- Reset mid-PLAYING with note 0x1A, duration 8 → all outputs 0, state IDLE, rom_addr 0 on the same cycle as reset.
- song=2, play rises, ROM[64]={0x11,4} → rom_addr 64; new_note and timer_clear high for one cycle 3 edges after play; note 0x11, duration 4.
- note_done pulse in PLAYING, ROM[65]={0x00,2} → rom_addr 65; new_note 3 edges later; note 0 (rest), duration 2.
- ROM[66] duration = 0 → no new_note; song_done = 1 held; play low → IDLE, song_done 0. With REPEAT_EN: one-cycle song_done pulse, then rom_addr 64 again.
- All 32 entries nonzero, 32 note_done pulses → after the 32nd, DONE. No fetch of address {song, 0} beyond index 31.
- song changes 2→3 on the same edge as note_done → rom_addr 96, index 0; no fetch of address 65. play dropped during FETCH → IDLE, no new_note.
